sim_state_dumper: RTL and testbench

- Synthesizable run-budget and state-dump engine for the riscv-g19 core.
- Counts execution cycles, then walks the register file and the low data-memory bytes through read ports.
- Streams each entry out over a valid/ready channel, then checks one memory byte against an expected value and raises pass/fail.
- Generalises the end-of-run register/memory dump and "MEM[0] == 0x07" check into a parametrised block usable on FPGA and in benches.

---
 rtl/sim_state_dumper.sv | 145 ++++++++++++++
 tb/tb_sim_state_dumper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_state_dumper.sv
// Run-budget counter and end-of-run state dumper: counts RUN cycles, streams the register
// file and low data memory over valid/ready, then checks one byte. Optional: DUMP_SKIP_ZERO_EN.
module sim_state_dumper #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned MEM_BYTES  = 32,
    parameter int unsigned MAX_CYCLES = 200,
    parameter int unsigned CHECK_ADDR = 0,
    parameter logic [7:0]  CHECK_VAL  = 8'h07,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         halt_i,
    output logic [$clog2(NUM_REGS)-1:0]  rf_raddr,
    input  logic [XLEN-1:0]              rf_rdata,
    output logic [$clog2(MEM_BYTES)-1:0] dm_raddr,
    input  logic [7:0]                   dm_rdata,
    output logic                         dump_valid,
    input  logic                         dump_ready,
    output logic                         dump_kind,
    output logic [15:0]                  dump_index,
    output logic [XLEN-1:0]              dump_data,
    output logic [CNT_W-1:0]             cycle_count,
    output logic                         done,
    output logic                         pass
);

    localparam int unsigned RF_AW = $clog2(NUM_REGS);
    localparam int unsigned DM_AW = $clog2(MEM_BYTES);
    localparam int unsigned IDX_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DUMP_RF,
        S_DUMP_MEM,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_inc;
    logic [XLEN-1:0]  rd_data;
    logic             dumping;
    logic             is_last;
    logic             step;
    logic             skip;
    logic             load;
    logic             run_exit;

    // The index counter is a flop, so both read addresses come straight from it.
    assign rf_raddr = idx[RF_AW-1:0];
    assign dm_raddr = idx[DM_AW-1:0];

    // Load/step decode and next-state logic.
    always_comb begin
        state_next = state;
        dumping    = (state == S_DUMP_RF) || (state == S_DUMP_MEM);
        rd_data    = (state == S_DUMP_MEM) ? XLEN'(dm_rdata) : rf_rdata;
        is_last    = (state == S_DUMP_MEM) ? (idx == IDX_W'(MEM_BYTES - 1))
                                           : (idx == IDX_W'(NUM_REGS - 1));
        step       = dumping && (!dump_valid || dump_ready);
`ifdef DUMP_SKIP_ZERO_EN
        skip       = (rd_data == '0);
`else
        skip       = 1'b0;
`endif
        load       = step && !skip;
        cnt_inc    = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);
        run_exit   = halt_i || (cnt_inc == CNT_W'(MAX_CYCLES));

        case (state)
            S_IDLE:     state_next = S_RUN;
            S_RUN:      if (run_exit) state_next = S_DUMP_RF;
            S_DUMP_RF:  if (step && is_last) state_next = S_DUMP_MEM;
            S_DUMP_MEM: if (step && is_last) state_next = S_DRAIN;
            S_DRAIN:    if (!dump_valid) state_next = S_CHECK;
            S_CHECK:    state_next = S_DONE;
            S_DONE:     state_next = S_DONE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: cycle counter, index walk, output beat register and check result.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            cycle_count <= '0;
            dump_valid  <= 1'b0;
            dump_kind   <= 1'b0;
            dump_index  <= '0;
            dump_data   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    cycle_count <= cnt_inc;
                end
                S_DUMP_RF, S_DUMP_MEM: begin
                    if (load) begin
                        dump_valid <= 1'b1;
                        dump_kind  <= (state == S_DUMP_MEM);
                        dump_index <= idx;
                        dump_data  <= rd_data;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                    end
                    if (step) begin
                        idx <= is_last ? '0 : idx + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                    end
                    // Park the address on the checked byte so CHECK reads it directly.
                    if (!dump_valid) begin
                        idx <= IDX_W'(CHECK_ADDR);
                    end
                end
                S_CHECK: begin
                    pass <= (dm_rdata == CHECK_VAL);
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_state_dumper.sv
// Directed bench for sim_state_dumper: scoreboarded beat stream, halt, stalls,
// check failure and mid-dump reset, with model-derived expected values.
module tb_sim_state_dumper;

`ifdef DUMP_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        halt_i;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [4:0]  dm_raddr;
    logic [7:0]  dm_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_kind;
    logic [15:0] dump_index;
    logic [31:0] dump_data;
    logic [15:0] cycle_count;
    logic        done;
    logic        pass;

    logic [31:0] rf_mem [32];
    logic [7:0]  dm_mem [32];

    logic [48:0] exp_q [$];
    logic [48:0] captured [64];
    logic [48:0] got_b;
    logic [48:0] exp_b;
    logic [48:0] held_b;
    logic        stall_prev;
    int          beats_seen;
    int          rdy_mode;
    int          errors;
    int          checks;

    sim_state_dumper dut (
        .clk        (clk),
        .rst        (rst),
        .halt_i     (halt_i),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .dm_raddr   (dm_raddr),
        .dm_rdata   (dm_rdata),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_kind  (dump_kind),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .cycle_count(cycle_count),
        .done       (done),
        .pass       (pass)
    );

    assign rf_rdata = rf_mem[rf_raddr];
    assign dm_rdata = dm_mem[dm_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base();
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i * 3);
            dm_mem[i] = 8'(i * 7 + 1);
        end
        rf_mem[5] = 32'h0000_002A;
        dm_mem[0] = 8'h07;
    endtask

    task automatic load_sparse();
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'h0;
            dm_mem[i] = 8'h0;
        end
        rf_mem[1] = 32'h1;
        rf_mem[2] = 32'h2;
        dm_mem[0] = 8'h07;
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < 32; i++)
            if (!(SKIP_ZERO && rf_mem[i] == 32'h0))
                exp_q.push_back({1'b0, 16'(i), rf_mem[i]});
        for (int i = 0; i < 32; i++)
            if (!(SKIP_ZERO && dm_mem[i] == 8'h0))
                exp_q.push_back({1'b1, 16'(i), 24'h0, dm_mem[i]});
    endtask

    // Consumer side: ready pattern 1,0,0 repeating when rdy_mode=1, else tied high.
    initial begin
        int ph;
        ph = 0;
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                dump_ready = 1'b1;
            end else begin
                dump_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    // Beat monitor, sampled mid-cycle ahead of the edge that transfers the beat.
    initial begin
        stall_prev = 1'b0;
        held_b = '0;
        forever begin
            @(negedge clk);
            got_b = {dump_kind, dump_index, dump_data};
            if (stall_prev && dump_valid && !rst)
                check("stall_hold", 64'(got_b), 64'(held_b));
            if (!rst && dump_valid && dump_ready) begin
                if (beats_seen < 64) captured[beats_seen] = got_b;
                if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                    check($sformatf("beat%0d", beats_seen), 64'(got_b), 64'(exp_b));
                end
                beats_seen++;
            end
            stall_prev = !rst && dump_valid && !dump_ready;
            held_b = got_b;
        end
    end

    task automatic do_run(input int halt_at, input int ready_mode, input int abort_at,
                          input logic [15:0] exp_cnt, input logic exp_pass);
        int n_exp;
        bit halted;
        bit fin;
        build_expected();
        n_exp = exp_q.size();
        beats_seen = 0;
        halted = 1'b0;
        fin = 1'b0;
        rst = 1'b1;
        halt_i = 1'b0;
        rdy_mode = ready_mode;
        tick();
        tick();
        check("rst_valid", 64'(dump_valid), 64'(0));
        check("rst_kind", 64'(dump_kind), 64'(0));
        check("rst_index", 64'(dump_index), 64'(0));
        check("rst_data", 64'(dump_data), 64'(0));
        check("rst_cnt", 64'(cycle_count), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_pass", 64'(pass), 64'(0));
        check("rst_rfaddr", 64'(rf_raddr), 64'(0));
        check("rst_dmaddr", 64'(dm_raddr), 64'(0));
        rst = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            tick();
            if (halt_i) halt_i = 1'b0;
            else if (halt_at >= 0 && !halted && cycle_count == 16'(halt_at)) begin
                halt_i = 1'b1;
                halted = 1'b1;
            end
            if (abort_at >= 0 && beats_seen == abort_at && dump_valid) begin
                rst = 1'b1;
                tick();
                check("abort_valid", 64'(dump_valid), 64'(0));
                check("abort_done", 64'(done), 64'(0));
                check("abort_cnt", 64'(cycle_count), 64'(0));
                rst = 1'b0;
                return;
            end
            if (done) fin = 1'b1;
        end
        check("done_timeout", 64'(done), 64'(1));
        check("cycle_count", 64'(cycle_count), 64'(exp_cnt));
        check("pass", 64'(pass), 64'(exp_pass));
        check("done_valid", 64'(dump_valid), 64'(0));
        check("beat_count", 64'(beats_seen), 64'(n_exp));
        check("beats_left", 64'(exp_q.size()), 64'(0));
        tick();
        tick();
        tick();
        check("cnt_frozen", 64'(cycle_count), 64'(exp_cnt));
        check("done_sticky", 64'(done), 64'(1));
        check("pass_held", 64'(pass), 64'(exp_pass));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        halt_i = 1'b0;
        rdy_mode = 0;
        beats_seen = 0;

        load_base();
        do_run(-1, 0, -1, 16'd200, 1'b1);
`ifndef DUMP_SKIP_ZERO_EN
        check("beat5_fields", 64'(captured[5]), 64'({1'b0, 16'd5, 32'h0000_002A}));
        check("beat32_fields", 64'(captured[32]), 64'({1'b1, 16'd0, 32'h0000_0007}));
`endif
        do_run(37, 0, -1, 16'd38, 1'b1);
        do_run(-1, 1, -1, 16'd200, 1'b1);

        dm_mem[0] = 8'h05;
        do_run(-1, 0, -1, 16'd200, 1'b0);
        dm_mem[0] = 8'h07;

        do_run(-1, 0, 40, 16'd0, 1'b0);
        do_run(-1, 0, -1, 16'd200, 1'b1);

        load_sparse();
        do_run(-1, 0, -1, 16'd200, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
